control_stage2: RTL and testbench

Backward-extension loop controller directly downstream of stage 1 in the SMEM backward pipeline. It registers stage 1's per-entry results and advances the inner index over the previous-iteration entry list. At the end of each list it either starts the next backward iteration or retires the read. It also produces every `*_q` feedback input consumed by stage 1.

---
 rtl/control_stage2.sv | 216 +++++++++++++++++++++
 tb/tb_control_stage2.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_stage2.sv
// Backward-extension loop controller (stage 2 of the SMEM backward pipeline).
// Optional perf counters are enabled by defining STAGE2_PERF_CNT_EN.
module control_stage2 #(
  parameter int          READ_NUM_WIDTH = 8,
  parameter logic [5:0]  BCK_INI        = 6'b00_1000,
  parameter logic [5:0]  BCK_RUN        = 6'b01_0000,
  parameter logic [5:0]  BCK_END        = 6'b10_0000,
  parameter logic [5:0]  BUBBLE         = 6'b00_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [5:0]                status,
  input  logic [READ_NUM_WIDTH-1:0] read_num,
  input  logic                      iteration_boundary,
  input  logic [7:0]                read_char,
  input  logic [6:0]                backward_i,
  input  logic [6:0]                backward_j,
  input  logic [6:0]                new_size,
  input  logic [6:0]                new_last_size,
  input  logic [6:0]                forward_size_n,
  input  logic [6:0]                min_intv,
  input  logic [6:0]                current_rd_addr,
  input  logic [6:0]                current_wr_addr,
  input  logic [6:0]                mem_wr_addr,
  input  logic [63:0]               primary,
  input  logic [63:0]               reserved_token_x2,
  input  logic [31:0]               reserved_mem_info,
  output logic [5:0]                status_q,
  output logic [READ_NUM_WIDTH-1:0] read_num_q,
  output logic                      iteration_boundary_q,
  output logic [6:0]                backward_i_q,
  output logic [6:0]                backward_j_q,
  output logic [6:0]                new_size_q,
  output logic [6:0]                new_last_size_q,
  output logic [6:0]                forward_size_n_q,
  output logic [6:0]                min_intv_q,
  output logic [6:0]                current_rd_addr_q,
  output logic [6:0]                current_wr_addr_q,
  output logic [6:0]                mem_wr_addr_q,
  output logic [63:0]               primary_q,
  output logic [63:0]               last_token_x2,
  output logic [31:0]               last_mem_info,
  output logic [7:0]                output_c_q,
  output logic                      bck_done,
  output logic [READ_NUM_WIDTH-1:0] bck_done_read_num,
  output logic [6:0]                bck_mem_count
`ifdef STAGE2_PERF_CNT_EN
  ,
  output logic [15:0]               perf_iter_cnt,
  output logic [15:0]               perf_entry_cnt
`endif
);

  logic [5:0]                status_d;
  logic [READ_NUM_WIDTH-1:0] read_num_d;
  logic                      iteration_boundary_d;
  logic [6:0]                backward_i_d, backward_j_d, new_size_d, new_last_size_d;
  logic [6:0]                forward_size_n_d, min_intv_d, current_rd_addr_d;
  logic [6:0]                current_wr_addr_d, mem_wr_addr_d;
  logic [63:0]               primary_d, last_token_x2_d;
  logic [31:0]               last_mem_info_d;
  logic [7:0]                output_c_d;
  logic                      bck_done_d;
  logic [READ_NUM_WIDTH-1:0] bck_done_read_num_d;
  logic [6:0]                bck_mem_count_d;
  logic [6:0]                last_idx;
  logic                      j_last;
  logic                      iter_adv;

  assign last_idx = new_last_size - 7'd1;
  assign j_last   = (backward_j == last_idx);

  always_comb begin
    status_d             = status;
    read_num_d           = read_num;
    iteration_boundary_d = iteration_boundary;
    backward_i_d         = backward_i;
    backward_j_d         = backward_j;
    new_size_d           = new_size;
    new_last_size_d      = new_last_size;
    forward_size_n_d     = forward_size_n;
    min_intv_d           = min_intv;
    current_rd_addr_d    = current_rd_addr;
    current_wr_addr_d    = current_wr_addr;
    mem_wr_addr_d        = mem_wr_addr;
    primary_d            = primary;
    last_token_x2_d      = reserved_token_x2;
    last_mem_info_d      = reserved_mem_info;
    output_c_d           = read_char;
    bck_done_d           = 1'b0;
    bck_done_read_num_d  = bck_done_read_num;
    bck_mem_count_d      = bck_mem_count;
    iter_adv             = 1'b0;

    if (status == BCK_INI) begin
      backward_j_d = 7'd0;
      status_d     = BCK_RUN;
    end else if (status == BCK_RUN) begin
      if (!j_last) begin
        backward_j_d = backward_j + 7'd1;
        status_d     = BCK_RUN;
      end else if ((new_size == 7'd0) || iteration_boundary) begin
        status_d            = BCK_END;
        bck_done_d          = 1'b1;
        bck_done_read_num_d = read_num;
        bck_mem_count_d     = mem_wr_addr;
      end else begin
        // Survivors of this pass become the list walked by the next iteration.
        iter_adv          = 1'b1;
        status_d          = BCK_RUN;
        new_last_size_d   = new_size;
        new_size_d        = 7'd0;
        backward_j_d      = 7'd0;
        current_wr_addr_d = forward_size_n - 7'd1;
        last_token_x2_d   = 64'd0;
        if (backward_i == 7'd0) begin
          iteration_boundary_d = 1'b1;
          backward_i_d         = 7'd0;
        end else begin
          iteration_boundary_d = 1'b0;
          backward_i_d         = backward_i - 7'd1;
        end
      end
    end else begin
      status_d             = BUBBLE;
      read_num_d           = '0;
      iteration_boundary_d = 1'b0;
      backward_i_d         = 7'd0;
      backward_j_d         = 7'd0;
      new_size_d           = 7'd0;
      new_last_size_d      = 7'd0;
      forward_size_n_d     = 7'd0;
      min_intv_d           = 7'd0;
      current_rd_addr_d    = 7'd0;
      current_wr_addr_d    = 7'd0;
      mem_wr_addr_d        = 7'd0;
      primary_d            = 64'd0;
      last_token_x2_d      = 64'd0;
      last_mem_info_d      = 32'd0;
      output_c_d           = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q             <= BUBBLE;
      read_num_q           <= '0;
      iteration_boundary_q <= 1'b0;
      backward_i_q         <= 7'd0;
      backward_j_q         <= 7'd0;
      new_size_q           <= 7'd0;
      new_last_size_q      <= 7'd0;
      forward_size_n_q     <= 7'd0;
      min_intv_q           <= 7'd0;
      current_rd_addr_q    <= 7'd0;
      current_wr_addr_q    <= 7'd0;
      mem_wr_addr_q        <= 7'd0;
      primary_q            <= 64'd0;
      last_token_x2        <= 64'd0;
      last_mem_info        <= 32'd0;
      output_c_q           <= 8'd0;
      bck_done             <= 1'b0;
      bck_done_read_num    <= '0;
      bck_mem_count        <= 7'd0;
    end else if (stall) begin
      // Hold everything; the retire is re-evaluated on the first free edge.
      bck_done <= 1'b0;
    end else begin
      status_q             <= status_d;
      read_num_q           <= read_num_d;
      iteration_boundary_q <= iteration_boundary_d;
      backward_i_q         <= backward_i_d;
      backward_j_q         <= backward_j_d;
      new_size_q           <= new_size_d;
      new_last_size_q      <= new_last_size_d;
      forward_size_n_q     <= forward_size_n_d;
      min_intv_q           <= min_intv_d;
      current_rd_addr_q    <= current_rd_addr_d;
      current_wr_addr_q    <= current_wr_addr_d;
      mem_wr_addr_q        <= mem_wr_addr_d;
      primary_q            <= primary_d;
      last_token_x2        <= last_token_x2_d;
      last_mem_info        <= last_mem_info_d;
      output_c_q           <= output_c_d;
      bck_done             <= bck_done_d;
      bck_done_read_num    <= bck_done_read_num_d;
      bck_mem_count        <= bck_mem_count_d;
    end
  end

`ifdef STAGE2_PERF_CNT_EN
  logic [15:0] perf_iter_cnt_q, perf_entry_cnt_q;

  assign perf_iter_cnt  = perf_iter_cnt_q;
  assign perf_entry_cnt = perf_entry_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_iter_cnt_q  <= 16'd0;
      perf_entry_cnt_q <= 16'd0;
    end else if (!stall) begin
      if (status == BCK_INI) begin
        perf_iter_cnt_q  <= 16'd0;
        perf_entry_cnt_q <= 16'd0;
      end else begin
        if (iter_adv && (perf_iter_cnt_q != 16'hFFFF))
          perf_iter_cnt_q <= perf_iter_cnt_q + 16'd1;
        if ((status == BCK_RUN) && (perf_entry_cnt_q != 16'hFFFF))
          perf_entry_cnt_q <= perf_entry_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_control_stage2.sv
// Directed bench for control_stage2: table of single-cycle vectors plus
// hand sequences for reset, stalled retire and reset during a stalled read.
module tb_control_stage2;

  localparam logic [5:0]  INI = 6'b00_1000;
  localparam logic [5:0]  RUN = 6'b01_0000;
  localparam logic [5:0]  ENDS = 6'b10_0000;
  localparam logic [5:0]  BUB = 6'b00_0000;
  localparam logic [63:0] TOK = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] PRI = 64'h0F0F_1234_5678_9ABC;
  localparam logic [31:0] MINFO = 32'h5A5A_A5A5;
  localparam logic [7:0]  RCHAR = 8'h41;
  localparam logic [6:0]  CWA = 7'd10;

  logic        clk, rst, stall;
  logic [5:0]  status;
  logic [7:0]  read_num;
  logic        iteration_boundary;
  logic [7:0]  read_char;
  logic [6:0]  backward_i, backward_j, new_size, new_last_size, forward_size_n;
  logic [6:0]  min_intv, current_rd_addr, current_wr_addr, mem_wr_addr;
  logic [63:0] primary, reserved_token_x2;
  logic [31:0] reserved_mem_info;
  logic [5:0]  status_q;
  logic [7:0]  read_num_q;
  logic        iteration_boundary_q;
  logic [6:0]  backward_i_q, backward_j_q, new_size_q, new_last_size_q, forward_size_n_q;
  logic [6:0]  min_intv_q, current_rd_addr_q, current_wr_addr_q, mem_wr_addr_q;
  logic [63:0] primary_q, last_token_x2;
  logic [31:0] last_mem_info;
  logic [7:0]  output_c_q;
  logic        bck_done;
  logic [7:0]  bck_done_read_num;
  logic [6:0]  bck_mem_count;
`ifdef STAGE2_PERF_CNT_EN
  logic [15:0] perf_iter_cnt, perf_entry_cnt;
`endif

  int checks = 0;
  int errors = 0;

  control_stage2 dut (
    .clk(clk), .rst(rst), .stall(stall), .status(status), .read_num(read_num),
    .iteration_boundary(iteration_boundary), .read_char(read_char),
    .backward_i(backward_i), .backward_j(backward_j), .new_size(new_size),
    .new_last_size(new_last_size), .forward_size_n(forward_size_n),
    .min_intv(min_intv), .current_rd_addr(current_rd_addr),
    .current_wr_addr(current_wr_addr), .mem_wr_addr(mem_wr_addr),
    .primary(primary), .reserved_token_x2(reserved_token_x2),
    .reserved_mem_info(reserved_mem_info),
    .status_q(status_q), .read_num_q(read_num_q),
    .iteration_boundary_q(iteration_boundary_q),
    .backward_i_q(backward_i_q), .backward_j_q(backward_j_q),
    .new_size_q(new_size_q), .new_last_size_q(new_last_size_q),
    .forward_size_n_q(forward_size_n_q), .min_intv_q(min_intv_q),
    .current_rd_addr_q(current_rd_addr_q), .current_wr_addr_q(current_wr_addr_q),
    .mem_wr_addr_q(mem_wr_addr_q), .primary_q(primary_q),
    .last_token_x2(last_token_x2), .last_mem_info(last_mem_info),
    .output_c_q(output_c_q), .bck_done(bck_done),
    .bck_done_read_num(bck_done_read_num), .bck_mem_count(bck_mem_count)
`ifdef STAGE2_PERF_CNT_EN
    , .perf_iter_cnt(perf_iter_cnt), .perf_entry_cnt(perf_entry_cnt)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  st;
    logic [6:0]  bi;
    logic [6:0]  bj;
    logic [6:0]  ns;
    logic [6:0]  nls;
    logic [6:0]  fsn;
    logic        ib;
    logic [6:0]  mwa;
    logic [7:0]  rn;
    logic [5:0]  e_st;
    logic [6:0]  e_bi;
    logic [6:0]  e_bj;
    logic [6:0]  e_ns;
    logic [6:0]  e_nls;
    logic [6:0]  e_cwa;
    logic        e_ib;
    logic        e_done;
    logic [63:0] e_tok;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] st, input logic [6:0] bi, input logic [6:0] bj,
                       input logic [6:0] ns, input logic [6:0] nls, input logic [6:0] fsn,
                       input logic ib, input logic [6:0] mwa, input logic [7:0] rn);
    status = st; backward_i = bi; backward_j = bj; new_size = ns;
    new_last_size = nls; forward_size_n = fsn; iteration_boundary = ib;
    mem_wr_addr = mwa; read_num = rn;
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{INI, 7'd9, 7'd3, 7'd0, 7'd5, 7'd5, 1'b0, 7'd0, 8'h01,
                 RUN, 7'd9, 7'd0, 7'd0, 7'd5, CWA, 1'b0, 1'b0, TOK};
    vecs[1]  = '{RUN, 7'd9, 7'd0, 7'd1, 7'd3, 7'd5, 1'b0, 7'd0, 8'h01,
                 RUN, 7'd9, 7'd1, 7'd1, 7'd3, CWA, 1'b0, 1'b0, TOK};
    vecs[2]  = '{RUN, 7'd9, 7'd1, 7'd1, 7'd3, 7'd5, 1'b0, 7'd0, 8'h01,
                 RUN, 7'd9, 7'd2, 7'd1, 7'd3, CWA, 1'b0, 1'b0, TOK};
    vecs[3]  = '{RUN, 7'd4, 7'd2, 7'd2, 7'd3, 7'd5, 1'b0, 7'd0, 8'h01,
                 RUN, 7'd3, 7'd0, 7'd0, 7'd2, 7'd4, 1'b0, 1'b0, 64'd0};
    vecs[4]  = '{RUN, 7'd0, 7'd1, 7'd1, 7'd2, 7'd5, 1'b0, 7'd0, 8'h01,
                 RUN, 7'd0, 7'd0, 7'd0, 7'd1, 7'd4, 1'b1, 1'b0, 64'd0};
    vecs[5]  = '{RUN, 7'd0, 7'd0, 7'd3, 7'd1, 7'd5, 1'b1, 7'd6, 8'h2A,
                 ENDS, 7'd0, 7'd0, 7'd3, 7'd1, CWA, 1'b1, 1'b1, TOK};
    vecs[6]  = '{INI, 7'd7, 7'd0, 7'd0, 7'd4, 7'd4, 1'b0, 7'd0, 8'h02,
                 RUN, 7'd7, 7'd0, 7'd0, 7'd4, CWA, 1'b0, 1'b0, TOK};
    vecs[7]  = '{BUB, 7'd5, 7'd2, 7'd2, 7'd3, 7'd5, 1'b1, 7'd3, 8'h02,
                 BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 64'd0};
    vecs[8]  = '{RUN, 7'd0, 7'd0, 7'd5, 7'd1, 7'd0, 1'b0, 7'd0, 8'h02,
                 RUN, 7'd0, 7'd0, 7'd0, 7'd5, 7'd127, 1'b1, 1'b0, 64'd0};
    vecs[9]  = '{ENDS, 7'd3, 7'd1, 7'd1, 7'd2, 7'd5, 1'b0, 7'd4, 8'h02,
                 BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 64'd0};
    vecs[10] = '{6'b00_0001, 7'd3, 7'd1, 7'd1, 7'd2, 7'd5, 1'b0, 7'd4, 8'h02,
                 BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 64'd0};
    vecs[11] = '{RUN, 7'd2, 7'd126, 7'd1, 7'd100, 7'd5, 1'b0, 7'd0, 8'h03,
                 RUN, 7'd2, 7'd127, 7'd1, 7'd100, CWA, 1'b0, 1'b0, TOK};
    vecs[12] = '{RUN, 7'd2, 7'd127, 7'd1, 7'd100, 7'd5, 1'b0, 7'd0, 8'h03,
                 RUN, 7'd2, 7'd0, 7'd1, 7'd100, CWA, 1'b0, 1'b0, TOK};
    vecs[13] = '{RUN, 7'd0, 7'd4, 7'd0, 7'd5, 7'd5, 1'b0, 7'd9, 8'h33,
                 ENDS, 7'd0, 7'd4, 7'd0, 7'd5, CWA, 1'b0, 1'b1, TOK};
    vecs[14] = '{BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 8'h00,
                 BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 64'd0};

    rst = 1'b0; stall = 1'b0;
    drive(RUN, 7'd3, 7'd1, 7'd2, 7'd4, 7'd5, 1'b1, 7'd2, 8'h55);
    read_char = RCHAR; min_intv = 7'd3; current_rd_addr = 7'd7;
    current_wr_addr = CWA; primary = PRI; reserved_token_x2 = TOK;
    reserved_mem_info = MINFO;
    tick(); tick();
    chk("reset status_q", 64'(status_q), 64'(BUB));
    chk("reset backward_j_q", 64'(backward_j_q), 64'd0);
    chk("reset primary_q", primary_q, 64'd0);
    chk("reset bck_done", 64'(bck_done), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].st, vecs[i].bi, vecs[i].bj, vecs[i].ns, vecs[i].nls,
            vecs[i].fsn, vecs[i].ib, vecs[i].mwa, vecs[i].rn);
      tick();
      chk($sformatf("v%0d status_q", i), 64'(status_q), 64'(vecs[i].e_st));
      chk($sformatf("v%0d backward_i_q", i), 64'(backward_i_q), 64'(vecs[i].e_bi));
      chk($sformatf("v%0d backward_j_q", i), 64'(backward_j_q), 64'(vecs[i].e_bj));
      chk($sformatf("v%0d new_size_q", i), 64'(new_size_q), 64'(vecs[i].e_ns));
      chk($sformatf("v%0d new_last_size_q", i), 64'(new_last_size_q), 64'(vecs[i].e_nls));
      chk($sformatf("v%0d current_wr_addr_q", i), 64'(current_wr_addr_q), 64'(vecs[i].e_cwa));
      chk($sformatf("v%0d iteration_boundary_q", i), 64'(iteration_boundary_q), 64'(vecs[i].e_ib));
      chk($sformatf("v%0d bck_done", i), 64'(bck_done), 64'(vecs[i].e_done));
      chk($sformatf("v%0d last_token_x2", i), last_token_x2, vecs[i].e_tok);
      chk($sformatf("v%0d mem_wr_addr_q", i), 64'(mem_wr_addr_q),
          (vecs[i].e_st == BUB) ? 64'd0 : 64'(vecs[i].mwa));
      chk($sformatf("v%0d output_c_q", i), 64'(output_c_q),
          (vecs[i].e_st == BUB) ? 64'd0 : 64'(RCHAR));
      chk($sformatf("v%0d last_mem_info", i), 64'(last_mem_info),
          (vecs[i].e_st == BUB) ? 64'd0 : 64'(MINFO));
      if (vecs[i].e_done) begin
        chk($sformatf("v%0d bck_mem_count", i), 64'(bck_mem_count), 64'(vecs[i].mwa));
        chk($sformatf("v%0d bck_done_read_num", i), 64'(bck_done_read_num), 64'(vecs[i].rn));
      end
    end

    // Stalled retire: one pulse only after stall releases.
    drive(RUN, 7'd5, 7'd0, 7'd1, 7'd3, 7'd5, 1'b0, 7'd6, 8'h2A);
    tick();
    chk("pre-stall backward_j_q", 64'(backward_j_q), 64'd1);
    stall = 1'b1;
    drive(RUN, 7'd5, 7'd0, 7'd0, 7'd1, 7'd5, 1'b0, 7'd6, 8'h2A);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d bck_done", c), 64'(bck_done), 64'd0);
      chk($sformatf("stall%0d status_q", c), 64'(status_q), 64'(RUN));
      chk($sformatf("stall%0d backward_j_q", c), 64'(backward_j_q), 64'd1);
      chk($sformatf("stall%0d new_last_size_q", c), 64'(new_last_size_q), 64'd3);
    end
    stall = 1'b0;
    tick();
    if (bck_done) pulses++;
    chk("release status_q", 64'(status_q), 64'(ENDS));
    chk("release bck_mem_count", 64'(bck_mem_count), 64'd6);
    chk("release bck_done_read_num", 64'(bck_done_read_num), 64'h2A);
    drive(BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bck_done) pulses++;
    end
    chk("post-retire status_q", 64'(status_q), 64'(BUB));
    chk("retire pulse count", 64'(pulses), 64'd1);

    // Reset during a stalled read.
    drive(INI, 7'd8, 7'd0, 7'd0, 7'd4, 7'd4, 1'b0, 7'd3, 8'h44);
    tick();
    drive(RUN, 7'd8, 7'd0, 7'd1, 7'd4, 7'd4, 1'b0, 7'd3, 8'h44);
    tick();
    chk("mid-read status_q", 64'(status_q), 64'(RUN));
    drive(RUN, 7'd8, 7'd3, 7'd0, 7'd4, 7'd4, 1'b0, 7'd3, 8'h44);
    stall = 1'b1; rst = 1'b0;
    tick();
    chk("rst-stall status_q", 64'(status_q), 64'(BUB));
    chk("rst-stall backward_i_q", 64'(backward_i_q), 64'd0);
    chk("rst-stall mem_wr_addr_q", 64'(mem_wr_addr_q), 64'd0);
    chk("rst-stall read_num_q", 64'(read_num_q), 64'd0);
    chk("rst-stall bck_done", 64'(bck_done), 64'd0);
    stall = 1'b0; rst = 1'b1;
    drive(BUB, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 7'd0, 8'h00);
    tick();
    chk("after-rst bck_done", 64'(bck_done), 64'd0);
    chk("after-rst status_q", 64'(status_q), 64'(BUB));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
